// File: rtl/prm_pkg.sv
// Shared types and widths for the PRM obstacle-frame accumulator slice.
package prm_pkg;
  localparam int PRM_CODE_W      = 15;
  localparam int PRM_FRAME_LEN_W = 16;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} prm_acc_state_t;
endpackage

// File: rtl/prm_popcount.sv
// Combinational popcount as a balanced binary adder tree stored heap-style.
module prm_popcount #(
  parameter int W  = 64,
  parameter int OW = $clog2(W+1)
)(
  input  logic [W-1:0]  in_vec,
  output logic [OW-1:0] cnt
);
  localparam int LVL = $clog2(W);
  localparam int N   = 1 << LVL;

  // Leaves live at [N-1 .. 2N-2]; node k sums its children 2k+1 and 2k+2.
  logic [OW-1:0] tree [2*N-1];

  for (genvar i = 0; i < N; i++) begin : g_leaf
    if (i < W) begin : g_used
      assign tree[N-1+i] = OW'(in_vec[i]);
    end else begin : g_pad
      assign tree[N-1+i] = '0;
    end
  end

  for (genvar k = 0; k < N-1; k++) begin : g_node
    assign tree[k] = tree[2*k+1] + tree[2*k+2];
  end

  assign cnt = tree[0];
endmodule

// File: rtl/prm_edge_mask_accum.sv
// Streams voxel codes to the edge checker bank and ORs the returned edge masks
// into a blocked-edge bitmap, delivered per frame over a valid/ready handshake.
module prm_edge_mask_accum
  import prm_pkg::*;
#(
  parameter int NUM_EDGES = 64,
  parameter int CODE_W    = PRM_CODE_W,
  parameter int CNT_W     = $clog2(NUM_EDGES+1)
)(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       obs_valid,
  output logic                       obs_ready,
  input  logic [CODE_W-1:0]          obs_code,
  input  logic                       obs_last,
  input  logic                       abort,
  output logic [CODE_W-1:0]          chk_code,
  input  logic [NUM_EDGES-1:0]       chk_mask,
  output logic                       mask_valid,
  input  logic                       mask_ready,
  output logic [NUM_EDGES-1:0]       mask_out,
  output logic [CNT_W-1:0]           mask_count,
  output logic [PRM_FRAME_LEN_W-1:0] frame_len
);
  prm_acc_state_t             state;
  logic [NUM_EDGES-1:0]       accum;
  logic                       pend;
  logic [PRM_FRAME_LEN_W-1:0] len;
  logic [NUM_EDGES-1:0]       acc_final;
  logic [CNT_W-1:0]           pop_cnt;

  assign obs_ready = (state == IDLE) || (state == ACCUM);

  // Checker bank result for the code registered last cycle folds in here.
  assign acc_final = accum | chk_mask;

  prm_popcount #(.W(NUM_EDGES), .OW(CNT_W)) u_pop (
    .in_vec (acc_final),
    .cnt    (pop_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      chk_code   <= '0;
      accum      <= '0;
      pend       <= 1'b0;
      len        <= '0;
      mask_valid <= 1'b0;
      mask_out   <= '0;
      mask_count <= '0;
      frame_len  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (abort) begin
            accum <= '0;
            pend  <= 1'b0;
          end else if (obs_valid) begin
            chk_code <= obs_code;
            accum    <= '0;
            pend     <= 1'b1;
            len      <= PRM_FRAME_LEN_W'(1);
            state    <= obs_last ? DRAIN : ACCUM;
          end
        end
        ACCUM: begin
          if (abort) begin
            accum <= '0;
            pend  <= 1'b0;
            state <= IDLE;
          end else begin
            if (pend) accum <= acc_final;
            pend <= obs_valid;
            if (obs_valid) begin
              chk_code <= obs_code;
              if (len != '1) len <= len + PRM_FRAME_LEN_W'(1);
              if (obs_last) state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            accum <= '0;
            pend  <= 1'b0;
            state <= IDLE;
          end else begin
            accum      <= acc_final;
            pend       <= 1'b0;
            mask_out   <= acc_final;
            mask_count <= pop_cnt;
            frame_len  <= len;
            mask_valid <= 1'b1;
            state      <= OUT;
          end
        end
        OUT: begin
          // Result is committed; abort is deliberately ignored here.
          if (mask_ready) begin
            mask_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// Directed bench for prm_edge_mask_accum with a one-hot stub checker bank.
module tb_prm_edge_mask_accum;
  localparam int NE = 4;
  localparam int CW = 15;
  localparam int KW = $clog2(NE+1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          obs_valid, obs_ready, obs_last, abort;
  logic [CW-1:0] obs_code, chk_code;
  logic [NE-1:0] chk_mask, mask_out;
  logic          mask_valid, mask_ready;
  logic [KW-1:0] mask_count;
  logic [15:0]   frame_len;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign chk_mask = 4'b0001 << chk_code[1:0];

  prm_edge_mask_accum #(.NUM_EDGES(NE), .CODE_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .obs_valid  (obs_valid),
    .obs_ready  (obs_ready),
    .obs_code   (obs_code),
    .obs_last   (obs_last),
    .abort      (abort),
    .chk_code   (chk_code),
    .chk_mask   (chk_mask),
    .mask_valid (mask_valid),
    .mask_ready (mask_ready),
    .mask_out   (mask_out),
    .mask_count (mask_count),
    .frame_len  (frame_len)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [CW-1:0] code, input logic last);
    obs_valid = 1'b1;
    obs_code  = code;
    obs_last  = last;
  endtask

  task automatic idle_in();
    obs_valid = 1'b0;
    obs_last  = 1'b0;
    obs_code  = '0;
  endtask

  task automatic chk_result(input string tag, input logic [3:0] m, input logic [2:0] c,
                            input logic [15:0] l);
    chk({tag, "_valid"}, 32'(mask_valid), 32'd1);
    chk({tag, "_mask"},  32'(mask_out),   32'(m));
    chk({tag, "_count"}, 32'(mask_count), 32'(c));
    chk({tag, "_len"},   32'(frame_len),  32'(l));
  endtask

  initial begin
    rst_n = 1'b0; abort = 1'b0; mask_ready = 1'b0;
    idle_in();
    #3;
    chk("rst_ready", 32'(obs_ready),  32'd1);
    chk("rst_code",  32'(chk_code),   32'd0);
    chk("rst_valid", 32'(mask_valid), 32'd0);
    chk("rst_mask",  32'(mask_out),   32'd0);
    chk("rst_count", 32'(mask_count), 32'd0);
    chk("rst_len",   32'(frame_len),  32'd0);
    #4 rst_n = 1'b1;
    tick();

    // Normal two-code frame
    offer(15'h0001, 1'b0); tick();
    chk("f1_code1", 32'(chk_code), 32'h1);
    offer(15'h0002, 1'b1); tick();
    chk("f1_ready_drain", 32'(obs_ready),  32'd0);
    chk("f1_valid_t1",    32'(mask_valid), 32'd0);
    idle_in(); tick();
    chk_result("f1", 4'b0110, 3'd2, 16'd2);
    mask_ready = 1'b1; tick();
    chk("f1_valid_done", 32'(mask_valid), 32'd0);
    chk("f1_ready_idle", 32'(obs_ready),  32'd1);
    chk("f1_hold_mask",  32'(mask_out),   32'h6);
    mask_ready = 1'b0;

    // Single-code frame with consumer backpressure
    offer(15'h0003, 1'b1); tick();
    chk("f2_valid_t1", 32'(mask_valid), 32'd0);
    offer(15'h0000, 1'b0); tick();
    chk_result("f2", 4'b1000, 3'd1, 16'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(mask_valid), 32'd1);
      chk("bp_ready", 32'(obs_ready),  32'd0);
      chk("bp_mask",  32'(mask_out),   32'h8);
      chk("bp_code",  32'(chk_code),   32'h3);
    end
    idle_in();
    mask_ready = 1'b1; tick();
    chk("bp_release_ready", 32'(obs_ready),  32'd1);
    chk("bp_release_valid", 32'(mask_valid), 32'd0);

    // Abort while draining: no result, stale bits must not leak
    offer(15'h0001, 1'b0); tick();
    offer(15'h0002, 1'b0); tick();
    offer(15'h0003, 1'b1); tick();
    idle_in(); abort = 1'b1; tick();
    chk("ab_valid",  32'(mask_valid), 32'd0);
    chk("ab_ready",  32'(obs_ready),  32'd1);
    abort = 1'b0; tick();
    chk("ab_valid2", 32'(mask_valid), 32'd0);
    chk("ab_keep",   32'(mask_out),   32'h8);
    offer(15'h0000, 1'b1); tick();
    idle_in(); tick();
    chk_result("ab_next", 4'b0001, 3'd1, 16'd1);
    tick();
    chk("ab_next_done", 32'(mask_valid), 32'd0);

    // Asynchronous reset in the middle of ACCUM
    offer(15'h0001, 1'b0); tick();
    offer(15'h0002, 1'b0); tick();
    idle_in();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_code",  32'(chk_code),   32'd0);
    chk("ar_mask",  32'(mask_out),   32'd0);
    chk("ar_count", 32'(mask_count), 32'd0);
    chk("ar_len",   32'(frame_len),  32'd0);
    chk("ar_valid", 32'(mask_valid), 32'd0);
    chk("ar_ready", 32'(obs_ready),  32'd1);
    #2 rst_n = 1'b1;
    tick();
    chk("ar_novalid", 32'(mask_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      offer(CW'(i), i == 3); tick();
    end
    idle_in(); tick();
    chk_result("ar_next", 4'hF, 3'd4, 16'd4);
    tick();

    // Long duplicate frame saturates the length counter; abort in OUT is ignored
    mask_ready = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      offer(15'h0001, i == 69999); tick();
    end
    idle_in(); tick();
    chk_result("sat", 4'b0010, 3'd1, 16'hFFFF);
    abort = 1'b1; tick();
    abort = 1'b0;
    chk("out_abort_valid", 32'(mask_valid), 32'd1);
    chk("out_abort_mask",  32'(mask_out),   32'h2);
    mask_ready = 1'b1; tick();
    chk("sat_done", 32'(mask_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
